// File: rtl/mult_wb_arbiter.sv
// -----------------------------------------------------------------------------
// mult_wb_arbiter
//
// Merges the M5 multiplier result stream with the main-pipeline writeback
// into the single register-file write port. The main pipeline always wins.
// Multiplier results that lose arbitration wait in an in-order FIFO and drain
// when the main pipeline is idle. A younger main write to the same register
// invalidates older queued (or incoming) multiplier results, so WAW ordering
// holds. Multiply issue is stalled early enough that every result already in
// M1..M5 still fits in the FIFO.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous, active-high
//   mult_regwrite  in   M5 result valid
//   mult_wreg      in   M5 destination register
//   mult_result    in   M5 result data
//   mult_zero      in   M5 zero flag
//   mult_overflow  in   M5 overflow flag (result is discarded)
//   main_wen       in   main-pipeline writeback enable
//   main_wreg      in   main-pipeline destination register
//   main_wdata     in   main-pipeline write data
//   rf_wen         out  register-file write enable (registered)
//   rf_waddr       out  register-file write address (registered, holds)
//   rf_wdata       out  register-file write data (registered, holds)
//   mult_zero_out  out  zero flag of a mult-sourced write, 0 otherwise
//   mult_stall     out  hold multiply issue (registered)
//   ovf_exc        out  one-cycle pulse: mult result discarded on overflow
//   drop_err       out  sticky: mult result lost on a full FIFO
// -----------------------------------------------------------------------------
module mult_wb_arbiter #(
  parameter int REG_SIZE   = 32,
  parameter int REG_ADDR   = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int INFLIGHT   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mult_regwrite,
  input  logic [REG_ADDR-1:0] mult_wreg,
  input  logic [REG_SIZE-1:0] mult_result,
  input  logic                mult_zero,
  input  logic                mult_overflow,
  input  logic                main_wen,
  input  logic [REG_ADDR-1:0] main_wreg,
  input  logic [REG_SIZE-1:0] main_wdata,
  output logic                rf_wen,
  output logic [REG_ADDR-1:0] rf_waddr,
  output logic [REG_SIZE-1:0] rf_wdata,
  output logic                mult_zero_out,
  output logic                mult_stall,
  output logic                ovf_exc,
  output logic                drop_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(FIFO_DEPTH - INFLIGHT);

  // FIFO storage: valid bits are control state, payload is plain storage.
  logic [FIFO_DEPTH-1:0] ent_valid_q, ent_valid_d;
  logic [REG_ADDR-1:0]   ent_wreg_q [FIFO_DEPTH];
  logic [REG_SIZE-1:0]   ent_data_q [FIFO_DEPTH];
  logic                  ent_zero_q [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic                rf_wen_q, rf_wen_d;
  logic [REG_ADDR-1:0] rf_waddr_q, rf_waddr_d;
  logic [REG_SIZE-1:0] rf_wdata_q, rf_wdata_d;
  logic                zero_out_q, zero_out_d;
  logic                stall_q, stall_d;
  logic                ovf_q, ovf_d;
  logic                drop_q, drop_d;

  logic main_req, mult_req, kill_in;
  logic fifo_empty, fifo_full;
  logic do_pop, do_bypass, want_push, do_push, do_drop;
  logic [FIFO_DEPTH-1:0] kill_mask;

  // ---------------------------------------------------------------------------
  // Request qualification and arbitration
  // ---------------------------------------------------------------------------
  assign main_req   = main_wen && (main_wreg != '0);
  assign mult_req   = mult_regwrite && (mult_wreg != '0) && !mult_overflow;
  // An incoming mult result to the same register is older than the main write.
  assign kill_in    = main_req && (mult_wreg == main_wreg);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);

  assign do_pop    = !main_req && !fifo_empty;
  // Bypass only with an empty FIFO, otherwise arrival order would break.
  assign do_bypass = !main_req && fifo_empty && mult_req;
  assign want_push = mult_req && !do_bypass && !kill_in;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push   = want_push && (!fifo_full || do_pop);
  assign do_drop   = want_push && fifo_full && !do_pop;

  always_comb begin
    kill_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      kill_mask[i] = main_req && (ent_wreg_q[i] == main_wreg);
    end
  end

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    zero_out_d = 1'b0;

    if (main_req) begin
      rf_wen_d   = 1'b1;
      rf_waddr_d = main_wreg;
      rf_wdata_d = main_wdata;
    end else if (do_pop) begin
      // A killed head is popped silently; address and data keep their values.
      if (ent_valid_q[rd_ptr_q]) begin
        rf_wen_d   = 1'b1;
        rf_waddr_d = ent_wreg_q[rd_ptr_q];
        rf_wdata_d = ent_data_q[rd_ptr_q];
        zero_out_d = ent_zero_q[rd_ptr_q];
      end
    end else if (do_bypass) begin
      rf_wen_d   = 1'b1;
      rf_waddr_d = mult_wreg;
      rf_wdata_d = mult_result;
      zero_out_d = mult_zero;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping and status
  // ---------------------------------------------------------------------------
  always_comb begin
    ent_valid_d = ent_valid_q & ~kill_mask;
    if (do_push) ent_valid_d[wr_ptr_q] = 1'b1;

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;

    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);

    // Stall leaves room for every result already in flight behind it.
    stall_d = (count_d >= STALL_CNT);
    ovf_d   = mult_regwrite && mult_overflow;
    drop_d  = drop_q || do_drop;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_valid_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      rf_wen_q    <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      zero_out_q  <= 1'b0;
      stall_q     <= 1'b0;
      ovf_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      ent_valid_q <= ent_valid_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      rf_wen_q    <= rf_wen_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      zero_out_q  <= zero_out_d;
      stall_q     <= stall_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
    end
  end

  // NOTE: the payload array is deliberately not reset; the cleared valid bits
  // and zero count make stale payload unreachable, and a resettable array
  // would cost a reset mux per storage bit.
  always_ff @(posedge clk) begin
    if (do_push) begin
      ent_wreg_q[wr_ptr_q] <= mult_wreg;
      ent_data_q[wr_ptr_q] <= mult_result;
      ent_zero_q[wr_ptr_q] <= mult_zero;
    end
  end

  assign rf_wen        = rf_wen_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign mult_zero_out = zero_out_q;
  assign mult_stall    = stall_q;
  assign ovf_exc       = ovf_q;
  assign drop_err      = drop_q;

endmodule

// File: tb/tb_mult_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_wb_arbiter
//
// Directed bench for mult_wb_arbiter. Every write the bench expects on the
// register-file port is pushed to a scoreboard queue when the stimulus is
// driven; a negedge monitor pops and compares each write the DUT produces and
// flags any write that was not expected. Status outputs are checked inline.
// -----------------------------------------------------------------------------
module tb_mult_wb_arbiter;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        zero;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mult_regwrite;
  logic [4:0]  mult_wreg;
  logic [31:0] mult_result;
  logic        mult_zero;
  logic        mult_overflow;
  logic        main_wen;
  logic [4:0]  main_wreg;
  logic [31:0] main_wdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mult_zero_out;
  logic        mult_stall;
  logic        ovf_exc;
  logic        drop_err;

  int  checks = 0;
  int  errors = 0;
  wr_t sb[$];

  mult_wb_arbiter #(
    .REG_SIZE(32), .REG_ADDR(5), .FIFO_DEPTH(8), .INFLIGHT(5)
  ) dut (
    .clk(clk), .reset(reset),
    .mult_regwrite(mult_regwrite), .mult_wreg(mult_wreg),
    .mult_result(mult_result), .mult_zero(mult_zero),
    .mult_overflow(mult_overflow),
    .main_wen(main_wen), .main_wreg(main_wreg), .main_wdata(main_wdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mult_zero_out(mult_zero_out), .mult_stall(mult_stall),
    .ovf_exc(ovf_exc), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    mult_regwrite = 1'b0; mult_wreg = '0; mult_result = '0;
    mult_zero = 1'b0; mult_overflow = 1'b0;
    main_wen = 1'b0; main_wreg = '0; main_wdata = '0;
  endtask

  task automatic drive_main(input logic [4:0] a, input logic [31:0] d);
    main_wen = 1'b1; main_wreg = a; main_wdata = d;
  endtask

  task automatic drive_mult(input logic [4:0] a, input logic [31:0] d,
                            input logic z, input logic ovf);
    mult_regwrite = 1'b1; mult_wreg = a; mult_result = d;
    mult_zero = z; mult_overflow = ovf;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d,
                           input logic z);
    wr_t w;
    w.addr = a; w.data = d; w.zero = z;
    sb.push_back(w);
  endtask

  // Advance one clock; outputs of that edge are stable on return.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every register-file write must be the oldest expected.
  always @(negedge clk) begin
    if (reset === 1'b0 && rf_wen === 1'b1) begin
      wr_t obs;
      wr_t exp;
      obs.addr = rf_waddr; obs.data = rf_wdata; obs.zero = mult_zero_out;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL unexpected_write observed=%0h expected=none", obs);
      end else begin
        exp = sb.pop_front();
        assert (obs === exp) else begin
          errors++;
          $error("FAIL rf_write observed=%0h expected=%0h", obs, exp);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    set_idle();
    #3;
    chk("reset_rf_wen", 64'(rf_wen), 64'd0);
    chk("reset_stall",  64'(mult_stall), 64'd0);
    chk("reset_drop",   64'(drop_err), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Bypass: empty FIFO, no main write.
    drive_mult(5'd7, 32'h15, 1'b0, 1'b0);
    expect_wr(5'd7, 32'h15, 1'b0);
    step();
    chk("bypass_wen",  64'(rf_wen), 64'd1);
    chk("bypass_addr", 64'(rf_waddr), 64'd7);
    set_idle();
    step();

    // Bypass with zero flag, then a main write while mult_zero is high.
    drive_mult(5'd8, 32'h0, 1'b1, 1'b0);
    expect_wr(5'd8, 32'h0, 1'b1);
    step();
    set_idle();
    mult_zero = 1'b1;
    drive_main(5'd3, 32'h1234);
    expect_wr(5'd3, 32'h1234, 1'b0);
    step();
    set_idle();
    step();

    // Conflict: main wins, mult result is queued and drains next cycle.
    drive_main(5'd3, 32'hAAAA);
    drive_mult(5'd4, 32'h5, 1'b0, 1'b0);
    expect_wr(5'd3, 32'hAAAA, 1'b0);
    expect_wr(5'd4, 32'h5, 1'b0);
    step();
    chk("conflict_c1_addr", 64'(rf_waddr), 64'd3);
    set_idle();
    step();
    chk("conflict_c2_addr", 64'(rf_waddr), 64'd4);
    chk("conflict_c2_wen",  64'(rf_wen), 64'd1);
    step();
    chk("conflict_drained", 64'(rf_wen), 64'd0);

    // WAW kill of a queued entry.
    drive_main(5'd2, 32'h22);
    drive_mult(5'd9, 32'h99, 1'b0, 1'b0);
    expect_wr(5'd2, 32'h22, 1'b0);
    step();
    set_idle();
    drive_main(5'd9, 32'h1);
    expect_wr(5'd9, 32'h1, 1'b0);
    step();
    set_idle();
    step();
    chk("waw_killed_pop_wen", 64'(rf_wen), 64'd0);
    chk("waw_hold_data",      64'(rf_wdata), 64'h1);
    step();

    // WAW kill of an incoming mult result in the same cycle.
    drive_main(5'd6, 32'h66);
    drive_mult(5'd6, 32'h77, 1'b0, 1'b0);
    expect_wr(5'd6, 32'h66, 1'b0);
    step();
    set_idle();
    step();
    chk("waw_in_no_write", 64'(rf_wen), 64'd0);

    // Overflow and r0 writes.
    drive_mult(5'd5, 32'hDEAD, 1'b0, 1'b1);
    step();
    chk("ovf_pulse",    64'(ovf_exc), 64'd1);
    chk("ovf_no_write", 64'(rf_wen), 64'd0);
    set_idle();
    drive_mult(5'd0, 32'h11, 1'b0, 1'b0);
    drive_main(5'd0, 32'h22);
    step();
    chk("ovf_pulse_end", 64'(ovf_exc), 64'd0);
    chk("r0_no_write",   64'(rf_wen), 64'd0);
    set_idle();
    step();

    // Stall and overflow of the FIFO: main holds the port for 9 cycles.
    for (int i = 0; i < 9; i++) begin
      drive_main(5'd1, 32'h100 + 32'(i));
      drive_mult(5'(10 + i), 32'h200 + 32'(i), 1'b0, 1'b0);
      expect_wr(5'd1, 32'h100 + 32'(i), 1'b0);
      step();
      chk($sformatf("fill_stall_%0d", i), 64'(mult_stall),
          64'((i + 1 >= 3) ? 1 : 0));
      chk($sformatf("fill_drop_%0d", i), 64'(drop_err),
          64'((i == 8) ? 1 : 0));
    end
    for (int i = 0; i < 8; i++) expect_wr(5'(10 + i), 32'h200 + 32'(i), 1'b0);
    set_idle();
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("drain_stall_%0d", k), 64'(mult_stall),
          64'((7 - k >= 3) ? 1 : 0));
      chk($sformatf("drain_drop_%0d", k), 64'(drop_err), 64'd1);
    end
    step();
    chk("drain_done", 64'(rf_wen), 64'd0);

    // Reset mid-drain: four queued entries are discarded.
    for (int i = 0; i < 4; i++) begin
      drive_main(5'd1, 32'h300 + 32'(i));
      drive_mult(5'(20 + i), 32'h400 + 32'(i), 1'b0, 1'b0);
      expect_wr(5'd1, 32'h300 + 32'(i), 1'b0);
      step();
    end
    set_idle();
    chk("pre_reset_stall", 64'(mult_stall), 64'd1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_wen",   64'(rf_wen), 64'd0);
    chk("async_rst_addr",  64'(rf_waddr), 64'd0);
    chk("async_rst_data",  64'(rf_wdata), 64'd0);
    chk("async_rst_zero",  64'(mult_zero_out), 64'd0);
    chk("async_rst_stall", 64'(mult_stall), 64'd0);
    chk("async_rst_ovf",   64'(ovf_exc), 64'd0);
    chk("async_rst_drop",  64'(drop_err), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("post_rst_wen_%0d", k), 64'(rf_wen), 64'd0);
    end
    chk("post_rst_stall", 64'(mult_stall), 64'd0);

    @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
